// File: rtl/mult_arb_pkg.sv
// Shared definitions for the two-requester multiplier arbiter:
// FSM state encoding, datapath widths and a saturating counter helper.
package mult_arb_pkg;

    localparam int OP_W  = 4;
    localparam int P_W   = 8;
    localparam int ID_W  = 1;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mult4_arbiter_array_mult4.sv
// Array_Mult4: combinational 4x4 unsigned array multiplier.
// Each row adds one shifted partial product (x gated by one bit of y).
module Array_Mult4
    import mult_arb_pkg::*;
(
    input  logic [OP_W-1:0] x,
    input  logic [OP_W-1:0] y,
    output logic [P_W-1:0]  p
);

    logic [P_W-1:0] acc;

    // accumulate the shifted partial-product rows
    always_comb begin
        acc = '0;
        for (int i = 0; i < OP_W; i++) begin
            acc = acc + ({{(P_W-OP_W){1'b0}}, (x & {OP_W{y[i]}})} << i);
        end
    end

    assign p = acc;

endmodule

// File: rtl/mult4_arbiter.sv
// mult4_arbiter: round-robin sharing of one Array_Mult4 between two
// valid/ready requesters; returns a registered product tagged with the id.
// Optional feature macro: MULT_ARB_STATS_EN adds per-requester grant counters.
//
// state | meaning
// IDLE  | grant decision, requester handshake
// MUL   | operand register drives the multiplier
// RESP  | product held until the consumer takes it
module mult4_arbiter
    import mult_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [OP_W-1:0]   req0_x,
    input  logic [OP_W-1:0]   req0_y,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [OP_W-1:0]   req1_x,
    input  logic [OP_W-1:0]   req1_y,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [P_W-1:0]    rsp_p,
    input  logic              rsp_ready
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
`endif
);

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr;
    logic [ID_W-1:0] win;
    logic            hs;
    logic [OP_W-1:0] op_x;
    logic [OP_W-1:0] op_y;
    logic [ID_W-1:0] op_id;
    logic [P_W-1:0]  mult_p;

    Array_Mult4 u_mult (
        .x (op_x),
        .y (op_y),
        .p (mult_p)
    );

    // winner selection, readies and next state; readies are held low in reset
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        hs         = 1'b0;
        win        = (req0_valid && req1_valid) ? rr : req1_valid;
        case (state)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    req0_ready = (win == 1'b0);
                    req1_ready = (win == 1'b1);
                    hs         = 1'b1;
                    state_nxt  = MUL;
                end
            end
            MUL:     state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // operand capture, product registration and round-robin pointer update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_x      <= '0;
            op_y      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
            rr        <= '0;
        end else begin
            if (hs) begin
                op_x  <= win ? req1_x : req0_x;
                op_y  <= win ? req1_y : req0_y;
                op_id <= win;
            end
            if (state == MUL) begin
                rsp_p     <= mult_p;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rr        <= ~rsp_id;
            end
        end
    end

`ifdef MULT_ARB_STATS_EN
    // saturating per-requester handshake counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (hs) begin
            if (win == 1'b0) gnt_cnt0 <= sat_inc(gnt_cnt0);
            else             gnt_cnt1 <= sat_inc(gnt_cnt1);
        end
    end
`endif

endmodule

// File: tb/tb_mult4_arbiter.sv
// Testbench for mult4_arbiter: transaction-level model predicts grants and
// products into a scoreboard queue; a monitor checks every presented response.
module tb_mult4_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v0, v1;
    logic [3:0] x0, y0, x1, y1;
    logic       r0, r1;
    logic       rsp_valid;
    logic [0:0] rsp_id;
    logic [7:0] rsp_p;
    logic       rsp_ready;
`ifdef MULT_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    mult4_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (v0),
        .req0_x     (x0),
        .req0_y     (y0),
        .req0_ready (r0),
        .req1_valid (v1),
        .req1_x     (x1),
        .req1_y     (y1),
        .req1_ready (r1),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_p      (rsp_p),
        .rsp_ready  (rsp_ready)
`ifdef MULT_ARB_STATS_EN
        ,
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit id;
        int p;
    } exp_t;

    exp_t sbq[$];
    bit   ids_seen[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   m_busy = 0;
    bit   m_rr = 0;
    bit   m_inflight = 0;
    int   hs_cyc = 0;
    bit   hs0, hs1;
    bit   prev_v = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model evaluated at the falling edge, predicting the next rising edge.
    task automatic model_check();
        bit exp0, exp1;
        hs0 = 0;
        hs1 = 0;
        if (!rst_n) begin
            chk("rst_ready0", r0, 0);
            chk("rst_ready1", r1, 0);
            m_busy = 0;
            m_rr   = 0;
            sbq.delete();
            return;
        end
        exp0 = 0;
        exp1 = 0;
        if (!m_busy) begin
            if (v0 && v1) begin
                exp0 = !m_rr;
                exp1 = m_rr;
            end else begin
                exp0 = v0;
                exp1 = v1;
            end
        end
        chk("ready0", r0, exp0);
        chk("ready1", r1, exp1);
        hs0 = v0 && r0;
        hs1 = v1 && r1;
        if (exp0 || exp1) begin
            exp_t e;
            e.id = exp1;
            e.p  = exp1 ? int'(x1) * int'(y1) : int'(x0) * int'(y0);
            sbq.push_back(e);
            m_busy     = 1;
            m_inflight = exp1;
            hs_cyc     = cyc;
        end else if (m_busy && rsp_valid && rsp_ready) begin
            m_busy = 0;
            m_rr   = !m_inflight;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    // mode 0: drop valid after handshake; 1: keep valid with new operands; 2: random
    task automatic run(input int n, input int mode, input bit rnd_rdy);
        for (int i = 0; i < n; i++) begin
            step();
            if (hs0) begin
                x0 = 4'($urandom);
                y0 = 4'($urandom);
                v0 = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom) : 1'b0;
            end else if (mode == 2 && !v0) begin
                v0 = 1'($urandom);
            end
            if (hs1) begin
                x1 = 4'($urandom);
                y1 = 4'($urandom);
                v1 = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom) : 1'b0;
            end else if (mode == 2 && !v1) begin
                v1 = 1'($urandom);
            end
            if (rnd_rdy) rsp_ready = (($urandom % 4) != 0);
        end
    endtask

    // Response monitor: compares every presented response with the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 0;
        end else begin
            if (rsp_valid) begin
                if (!prev_v) chk("latency", cyc - hs_cyc, 2);
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_rsp: got id=%0d p=%0h expected no response", rsp_id, rsp_p);
                end else begin
                    chk("rsp_id", rsp_id, sbq[0].id);
                    chk("rsp_p", rsp_p, sbq[0].p);
                    if (rsp_ready) begin
                        ids_seen.push_back(rsp_id[0]);
                        void'(sbq.pop_front());
                    end
                end
            end
            prev_v = rsp_valid;
        end
    end

    initial begin
        int idx;
        bit start_rr;
`ifdef MULT_ARB_STATS_EN
        logic [15:0] base0, base1;
`endif
        rst_n = 0;
        v0 = 1; x0 = 4'h3; y0 = 4'h5;
        v1 = 1; x1 = 4'hF; y1 = 4'hF;
        rsp_ready = 1;
        repeat (3) step();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_p", rsp_p, 0);
        chk("rst_rsp_id", rsp_id, 0);
        rst_n = 1;

        // contention straight after reset: 0x0F for id 0, then 0xE1 for id 1
        idx = ids_seen.size();
        run(10, 0, 0);
        chk("cont_ops", ids_seen.size() - idx, 2);
        if (ids_seen.size() >= idx + 2) begin
            chk("cont_first_id", ids_seen[idx], 0);
            chk("cont_second_id", ids_seen[idx+1], 1);
        end

        // single request
        v0 = 1; x0 = 4'h4; y0 = 4'h4;
        run(6, 0, 0);

        // back-pressure with both requesters waiting
        rsp_ready = 0;
        v0 = 1; x0 = 4'h7; y0 = 4'h9;
        v1 = 1; x1 = 4'hA; y1 = 4'h6;
        run(8, 0, 0);
        rsp_ready = 1;
        run(8, 0, 0);

        // fairness: continuous contention for six operations
        v0 = 0; v1 = 0;
        run(4, 0, 0);
        idx = ids_seen.size();
        start_rr = m_rr;
`ifdef MULT_ARB_STATS_EN
        base0 = gnt_cnt0;
        base1 = gnt_cnt1;
`endif
        v0 = 1; v1 = 1;
        run(18, 1, 0);
        v0 = 0; v1 = 0;
        run(4, 0, 0);
        chk("fair_ops", ids_seen.size() - idx, 6);
        for (int i = 0; i < 6 && idx + i < ids_seen.size(); i++)
            chk("fair_id", ids_seen[idx+i], 32'(start_rr ^ i[0]));
`ifdef MULT_ARB_STATS_EN
        chk("fair_cnt0", gnt_cnt0 - base0, 3);
        chk("fair_cnt1", gnt_cnt1 - base1, 3);
`endif

        // reset while the operation is in MUL
        v0 = 1; x0 = 4'hC; y0 = 4'hD;
        step();
        v0 = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        run(4, 0, 0);
        idx = ids_seen.size();
        v0 = 1; x0 = 4'h2; y0 = 4'h9;
        v1 = 1; x1 = 4'h8; y1 = 4'h3;
        run(8, 0, 0);
        if (ids_seen.size() > idx) chk("post_rst_winner", ids_seen[idx], 0);
        else chk("post_rst_ops", ids_seen.size() - idx, 1);

        // randomized traffic with random back-pressure
        run(400, 2, 1);
        v0 = 0; v1 = 0; rsp_ready = 1;
        run(10, 0, 0);
        chk("drain_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
